// File: rtl/rx_align_pkg.sv
// rtl/rx_align_pkg.sv - shared lane state encoding and counter sizing for word alignment
package rx_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_ERROR
    } lane_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_align_lane.sv
// rtl/rx_align_lane.sv - one lane's bitslip search FSM, counters and registered status
module rx_align_lane
    import rx_align_pkg::*;
#(
    parameter int             S          = 8,
    parameter logic [S-1:0]   TRAIN_PAT  = 8'h0F,
    parameter int             LOCK_COUNT = 64,
    parameter int             SLIP_WAIT  = 16
) (
    input  logic         gclk,
    input  logic         reset_n,
    input  logic [S-1:0] lane_data,
    input  logic         train_en,
    input  logic         train_rise,
    output logic         bitslip,
    output logic         lane_locked,
    output logic         align_err
);

    localparam int MW = cnt_width(LOCK_COUNT);
    localparam int SW = cnt_width(S);
    localparam int WW = cnt_width(SLIP_WAIT);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0] SLIP_MAX   = SW'(S);
    // The SLIP cycle is the first settle cycle, so WAIT leaves as the count reaches SLIP_WAIT-1.
    localparam logic [WW-1:0] WAIT_LAST  = WW'((SLIP_WAIT >= 2) ? SLIP_WAIT - 2 : 0);

    lane_state_t   state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [SW-1:0] slip_q,  slip_d;
    logic [WW-1:0] wait_q,  wait_d;

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            match_q     <= '0;
            slip_q      <= '0;
            wait_q      <= '0;
            bitslip     <= 1'b0;
            lane_locked <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            slip_q      <= slip_d;
            wait_q      <= wait_d;
            bitslip     <= (state_d == ST_SLIP);
            lane_locked <= (state_d == ST_LOCKED);
            align_err   <= (state_d == ST_ERROR);
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        slip_d  = slip_q;
        wait_d  = wait_q;

        if (train_rise) begin
            state_d = ST_CHECK;
            match_d = '0;
            slip_d  = '0;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_CHECK, ST_SLIP, ST_WAIT: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                        match_d = '0;
                        slip_d  = '0;
                        wait_d  = '0;
                    end else if (state_q == ST_CHECK) begin
                        if (lane_data == TRAIN_PAT) begin
                            match_d = match_q + 1'b1;
                            if (match_q == MATCH_LAST)
                                state_d = ST_LOCKED;
                        end else begin
                            match_d = '0;
                            state_d = (slip_q == SLIP_MAX) ? ST_ERROR : ST_SLIP;
                        end
                    end else if (state_q == ST_SLIP) begin
                        slip_d  = slip_q + 1'b1;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                        if (wait_q == WAIT_LAST)
                            state_d = ST_CHECK;
                    end
                end
                ST_ERROR: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                        match_d = '0;
                        slip_d  = '0;
                        wait_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rx_word_align_ctrl.sv
// rtl/rx_word_align_ctrl.sv - per-lane word alignment controller with data forwarding and aggregate lock
module rx_word_align_ctrl
    import rx_align_pkg::*;
#(
    parameter int             S          = 8,
    parameter int             D          = 4,
    parameter logic [S-1:0]   TRAIN_PAT  = 8'h0F,
    parameter int             LOCK_COUNT = 64,
    parameter int             SLIP_WAIT  = 16
) (
    input  logic           gclk,
    input  logic           reset_n,
    input  logic [D*S-1:0] rxd,
    input  logic           train_en,
    output logic [D-1:0]   bitslip,
    output logic [D*S-1:0] dataout,
    output logic [D-1:0]   lane_locked,
    output logic           all_locked,
    output logic [D-1:0]   align_err
);

    logic train_q;
    logic train_rise;

    assign train_rise = train_en & ~train_q;

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            train_q    <= 1'b0;
            dataout    <= '0;
            all_locked <= 1'b0;
        end else begin
            train_q    <= train_en;
            dataout    <= rxd;
            all_locked <= &lane_locked;
        end
    end

    for (genvar i = 0; i < D; i++) begin : g_lane
        rx_align_lane #(
            .S          (S),
            .TRAIN_PAT  (TRAIN_PAT),
            .LOCK_COUNT (LOCK_COUNT),
            .SLIP_WAIT  (SLIP_WAIT)
        ) u_lane (
            .gclk        (gclk),
            .reset_n     (reset_n),
            .lane_data   (rxd[i*S +: S]),
            .train_en    (train_en),
            .train_rise  (train_rise),
            .bitslip     (bitslip[i]),
            .lane_locked (lane_locked[i]),
            .align_err   (align_err[i])
        );
    end

endmodule
